multicycle_controller: RTL

Multi-cycle control FSM for the RV32I core in the `CU` directory. It sequences the shared datapath (PC, IR, register file, ALU, data memory) over several cycles per instruction. It drives the 3-bit `alu_op` class into the existing ALU decoder and selects the datapath muxes. It also handshakes with a single shared instruction/data memory port.

---
 rtl/cu_pkg.sv | 56 +++++
 rtl/branch_eval.sv | 26 ++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared control-unit definitions: ALU instruction classes, opcodes, mux selects, FSM states.
package cu_pkg;

    typedef enum logic [2:0] {
        CLS_RIALU  = 3'b000,
        CLS_I      = 3'b001,
        CLS_S      = 3'b010,
        CLS_B      = 3'b011,
        CLS_U      = 3'b100,
        CLS_U_LUI  = 3'b101,
        CLS_J_JALR = 3'b110,
        CLS_J_JAL  = 3'b111
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_LINK   = 2'b11;

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADR   = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R    = 4'd6;
    localparam logic [3:0] ST_EXEC_I    = 4'd7;
    localparam logic [3:0] ST_ALU_WB    = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_JAL       = 4'd10;
    localparam logic [3:0] ST_JALR      = 4'd11;
    localparam logic [3:0] ST_JALR_WB   = 4'd12;
    localparam logic [3:0] ST_LUI       = 4'd13;
    localparam logic [3:0] ST_AUIPC     = 4'd14;
    localparam logic [3:0] ST_TRAP      = 4'd15;

endpackage

// File: rtl/branch_eval.sv
// Branch condition from funct3 and ALU compare flags; purely combinational.
// legal drops for the two reserved funct3 encodings so DECODE can trap them.
module branch_eval (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: Moore-decoded datapath controls, memory strobes gated by mem_ready.
// Outputs are forced low combinationally while rst is high, including an in-flight mem_req.
module multicycle_controller
    import cu_pkg::*;
#(
    parameter int unsigned ALUOP_WIDTH = 3,
    parameter int unsigned OP_WIDTH    = 7,
    parameter int unsigned F3_WIDTH    = 3,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic [F3_WIDTH-1:0]    funct3,
    input  logic                   zero,
    input  logic                   lt,
    input  logic                   ltu,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_write,
    output logic                   adr_src,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             result_src,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   instr_done,
    output logic                   illegal,
    output logic [CNT_WIDTH-1:0]   instret
);

    logic [3:0] state, state_nxt;
    logic       br_taken, br_legal;

    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
    alu_class_t alu_op_c;
    logic       done_c, illegal_c;

    branch_eval u_branch_eval (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (br_taken),
        .legal  (br_legal)
    );

    always_comb begin
        state_nxt    = state;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        result_src_c = RES_ALUOUT;
        alu_op_c     = CLS_RIALU;
        done_c       = 1'b0;
        illegal_c    = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALU;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
                if (mem_ready) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = ST_MEM_ADR;
                    OP_OP:             state_nxt = ST_EXEC_R;
                    OP_IMM:            state_nxt = ST_EXEC_I;
                    OP_BRANCH:         state_nxt = br_legal ? ST_BRANCH : ST_TRAP;
                    OP_JAL:            state_nxt = ST_JAL;
                    OP_JALR:           state_nxt = ST_JALR;
                    OP_LUI:            state_nxt = ST_LUI;
                    OP_AUIPC:          state_nxt = ST_AUIPC;
                    default:           state_nxt = ST_TRAP;
                endcase
            end
            ST_MEM_ADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = (op == OP_STORE) ? CLS_S : CLS_I;
                state_nxt   = (op == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) state_nxt = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                result_src_c = RES_MEM;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                done_c      = mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a_c = SRCA_RS1;
                state_nxt   = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_nxt   = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_c = SRCA_RS1;
                alu_op_c    = CLS_B;
                pc_write_c  = br_taken;
                done_c      = 1'b1;
            end
            ST_JAL: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = CLS_J_JAL;
                state_nxt   = ST_JALR_WB;
            end
            ST_JALR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = CLS_J_JALR;
                state_nxt   = ST_JALR_WB;
            end
            // Target already sits in ALUOut; rd gets oldPC+4 through the link path.
            ST_JALR_WB: begin
                pc_write_c   = 1'b1;
                reg_write_c  = 1'b1;
                result_src_c = RES_LINK;
                done_c       = 1'b1;
            end
            ST_LUI: begin
                alu_src_a_c = SRCA_ZERO;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = CLS_U_LUI;
                state_nxt   = ST_ALU_WB;
            end
            ST_AUIPC: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = CLS_U;
                state_nxt   = ST_ALU_WB;
            end
            ST_TRAP: illegal_c = 1'b1;
            default: state_nxt = ST_FETCH;
        endcase
        if (done_c) state_nxt = ST_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FETCH;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (done_c) instret <= instret + CNT_WIDTH'(1);
        end
    end

    assign mem_req    = mem_req_c   & ~rst;
    assign mem_write  = mem_write_c & ~rst;
    assign adr_src    = adr_src_c   & ~rst;
    assign ir_write   = ir_write_c  & ~rst;
    assign pc_write   = pc_write_c  & ~rst;
    assign reg_write  = reg_write_c & ~rst;
    assign alu_src_a  = rst ? 2'b00 : alu_src_a_c;
    assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
    assign result_src = rst ? 2'b00 : result_src_c;
    assign alu_op     = rst ? '0 : ALUOP_WIDTH'(alu_op_c);
    assign instr_done = done_c    & ~rst;
    assign illegal    = illegal_c & ~rst;

endmodule
